// File: rtl/pattern_detector.sv
// Serial pattern detector: compares a shift history of accepted bits against a
// latched pattern of programmable length, with overlapping or non-overlapping
// detection, a registered match pulse and a saturating match counter.
//
// Handshake: a data bit is accepted on a rising edge only when the detector is
// ACTIVE, i_in_valid=1 and i_cfg_load=0. There is no backpressure. A
// configuration load always takes priority over a data bit on the same edge.
module pattern_detector #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_in,
    input  logic               i_in_valid,
    input  logic               i_cfg_load,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic [LEN_W-1:0]   i_pat_len,
    input  logic               i_overlap,
    output logic               o_out,
    output logic [CNT_W-1:0]   o_match_cnt,
    output logic               o_active,
    output logic               o_cfg_err,
    output logic               o_state
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    logic [0:0]         r_state;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_pat_len;
    logic               r_overlap;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_out;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_cfg_err;

    logic               w_len_ok;
    logic               w_accept;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W-1:0]   w_fill_next;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_match;

    // Configuration legality and bit-acceptance qualification.
    always_comb begin
        w_len_ok = (i_pat_len >= LEN_W'(2)) && (i_pat_len <= LEN_W'(MAX_LEN));
        w_accept = (r_state == S_ACTIVE) && i_in_valid && !i_cfg_load;
    end

    // Next history/fill and the match test on the updated history; only the
    // low r_pat_len positions take part in the compare.
    always_comb begin
        w_hist_next = {r_hist[MAX_LEN-2:0], i_in};
        w_fill_next = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
        w_mask      = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            w_mask[k] = (LEN_W'(k) < r_pat_len);
        end
        w_match = w_accept && (w_fill_next >= r_pat_len) &&
                  (((w_hist_next ^ r_pattern) & w_mask) == '0);
    end

    // Control FSM and latched configuration.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_pattern <= '0;
            r_pat_len <= '0;
            r_overlap <= 1'b0;
            r_cfg_err <= 1'b0;
        end else if (i_cfg_load) begin
            if (w_len_ok) begin
                r_state   <= S_ACTIVE;
                r_pattern <= i_pattern;
                r_pat_len <= i_pat_len;
                r_overlap <= i_overlap;
                r_cfg_err <= 1'b0;
            end else begin
                r_state   <= S_IDLE;
                r_cfg_err <= 1'b1;
            end
        end
    end

    // History, fill counter, match pulse and saturating match counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_out  <= 1'b0;
            r_cnt  <= '0;
        end else if (i_cfg_load) begin
            // Any load starts from a clean slate; a rejected load also leaves
            // the detector idle, so no stale bits can survive into a later one.
            r_hist <= '0;
            r_fill <= '0;
            r_out  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_hist <= w_hist_next;
            r_out  <= w_match;
            // Non-overlapping mode restarts the fill count so none of the
            // matched bits can count toward the next match.
            if (w_match && !r_overlap) begin
                r_fill <= '0;
            end else begin
                r_fill <= w_fill_next;
            end
            if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_out <= 1'b0;
        end
    end

    assign o_out       = r_out;
    assign o_match_cnt = r_cnt;
    assign o_active    = (r_state == S_ACTIVE);
    assign o_cfg_err   = r_cfg_err;
    assign o_state     = r_state;

endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector: a default-parameter instance and a
// CNT_W=2 instance share all inputs; expected match pulses are queued when a
// step is driven and compared after the edge.
module tb_pattern_detector;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               din;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap;

    logic               out_a, active_a, err_a, state_a;
    logic [7:0]         cnt_a;
    logic               out_b, active_b, err_b, state_b;
    logic [1:0]         cnt_b;

    int total = 0;
    int bad   = 0;
    logic [0:0] exp_q[$];

    pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_in(din), .i_in_valid(in_valid),
        .i_cfg_load(cfg_load), .i_pattern(pattern), .i_pat_len(pat_len),
        .i_overlap(overlap), .o_out(out_a), .o_match_cnt(cnt_a),
        .o_active(active_a), .o_cfg_err(err_a), .o_state(state_a)
    );

    pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_in(din), .i_in_valid(in_valid),
        .i_cfg_load(cfg_load), .i_pattern(pattern), .i_pat_len(pat_len),
        .i_overlap(overlap), .o_out(out_b), .o_match_cnt(cnt_b),
        .o_active(active_b), .o_cfg_err(err_b), .o_state(state_b)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Pop the oldest expected pulse value and compare both instances.
    task automatic score(input string tag);
        logic [0:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_q_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {31'd0, out_a}, {31'd0, e});
            chk({tag, "_b"}, {31'd0, out_b}, {31'd0, e});
        end
    endtask

    // driver: one clock with optional data bit; expected pulse queued first
    task automatic step(input logic b, input logic v, input logic exp_out, input string tag);
        exp_q.push_back(exp_out);
        @(negedge clk);
        din      = b;
        in_valid = v;
        cfg_load = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        score(tag);
    endtask

    // driver: cfg_load strobe, optionally with a simultaneous data bit
    task automatic cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                       input logic ov, input logic v, input logic b);
        exp_q.push_back(1'b0);
        @(negedge clk);
        pattern  = p;
        pat_len  = l;
        overlap  = ov;
        cfg_load = 1'b1;
        in_valid = v;
        din      = b;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
        score("cfg_out");
    endtask

    // Send n bits (seq[n-1] first); e[n-1] is the pulse expected after the first bit.
    task automatic bits(input logic [15:0] seq, input logic [15:0] e, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(seq[i], 1'b1, e[i], tag);
        end
    endtask

    task automatic gap(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b0, tag);
        end
    endtask

    task automatic chk_status(input string tag, input logic act, input logic err, input logic [7:0] cnt);
        chk({tag, "_active"}, {31'd0, active_a}, {31'd0, act});
        chk({tag, "_state"},  {31'd0, state_a},  {31'd0, act});
        chk({tag, "_err"},    {31'd0, err_a},    {31'd0, err});
        chk({tag, "_cnt"},    {24'd0, cnt_a},    {24'd0, cnt});
    endtask

    initial begin
        int g;
        rst = 1'b1; din = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
        pattern = '0; pat_len = '0; overlap = 1'b0;
        #3;
        chk("reset_out", {31'd0, out_a}, 32'd0);
        chk_status("reset", 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset: bits are ignored.
        bits(16'b101, 16'b000, 3, "idle_bits");
        chk_status("idle", 1'b0, 1'b0, 8'd0);

        // Overlapping 101 over 1,0,1,0,1.
        cfg(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
        chk_status("cfg_ov", 1'b1, 1'b0, 8'd0);
        bits(16'b10101, 16'b00101, 5, "ov_101");
        chk_status("ov_101", 1'b1, 1'b0, 8'd2);

        // Non-overlapping, same stream, then 1,0,1,1,0,1.
        cfg(8'b101, 4'd3, 1'b0, 1'b0, 1'b0);
        chk_status("cfg_nov", 1'b1, 1'b0, 8'd0);
        bits(16'b10101, 16'b00100, 5, "nov_101");
        chk_status("nov_a", 1'b1, 1'b0, 8'd1);
        cfg(8'b101, 4'd3, 1'b0, 1'b0, 1'b0);
        bits(16'b101101, 16'b001001, 6, "nov_101101");
        chk_status("nov_b", 1'b1, 1'b0, 8'd2);

        // Gapped stream with random gap lengths (at least 2 idle cycles).
        cfg(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, "gap_b1");
        g = $urandom_range(2, 4);
        gap(g, "gap_idle1");
        step(1'b0, 1'b1, 1'b0, "gap_b2");
        g = $urandom_range(2, 4);
        gap(g, "gap_idle2");
        step(1'b1, 1'b1, 1'b1, "gap_b3");
        gap(2, "gap_after");
        chk_status("gap", 1'b1, 1'b0, 8'd1);

        // Saturation on the CNT_W=2 instance: pattern 11, six 1s.
        cfg(8'b11, 4'd2, 1'b1, 1'b0, 1'b0);
        bits(16'b1111, 16'b0111, 4, "sat_first4");
        chk("sat_b_at3", {30'd0, cnt_b}, 32'd3);
        bits(16'b11, 16'b11, 2, "sat_last2");
        chk("sat_b_hold", {30'd0, cnt_b}, 32'd3);
        chk("sat_a_cnt", {24'd0, cnt_a}, 32'd5);

        // Illegal lengths, then a legal load.
        cfg(8'b101, 4'd0, 1'b1, 1'b0, 1'b0);
        chk_status("len0", 1'b0, 1'b1, 8'd0);
        bits(16'b101, 16'b000, 3, "len0_bits");
        cfg(8'b101, 4'(MAX_LEN + 1), 1'b1, 1'b0, 1'b0);
        chk_status("len9", 1'b0, 1'b1, 8'd0);
        bits(16'b101, 16'b000, 3, "len9_bits");
        cfg(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
        chk_status("legal", 1'b1, 1'b0, 8'd0);

        // Full-length pattern and bits above pat_len ignored.
        cfg(8'b1100_1010, 4'd8, 1'b1, 1'b0, 1'b0);
        bits(16'b1100_1010, 16'b0000_0001, 8, "len8");
        chk_status("len8", 1'b1, 1'b0, 8'd1);
        cfg(8'b1111_0101, 4'd3, 1'b1, 1'b0, 1'b0);
        bits(16'b101, 16'b001, 3, "upper_ignored");

        // cfg_load wins over a same-edge data bit.
        cfg(8'b101, 4'd3, 1'b1, 1'b1, 1'b1);
        bits(16'b01, 16'b00, 2, "cfg_wins");
        chk_status("cfg_wins", 1'b1, 1'b0, 8'd0);

        // Reset mid-sequence discards the partial match.
        cfg(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
        bits(16'b10, 16'b00, 2, "pre_rst");
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_out", {31'd0, out_a}, 32'd0);
        chk_status("mid_rst", 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        bits(16'b1, 16'b0, 1, "post_rst_idle");
        cfg(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
        bits(16'b1, 16'b0, 1, "post_rst_1");
        bits(16'b01, 16'b01, 2, "post_rst_01");
        chk_status("post_rst", 1'b1, 1'b0, 8'd1);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits; legal range 2..32.
REQ-002 Parameter CNT_W, default 8: match counter width in bits.
REQ-003 Parameter LEN_W, default $clog2(MAX_LEN+1): width of the pattern-length port.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 in  input  1: serial data bit.
REQ-007 in_valid  input  1: qualifies in; a bit is accepted only on an edge where in_valid=1.
REQ-008 cfg_load  input  1: one-cycle strobe latching pattern, pat_len and overlap.
REQ-009 pattern  input  MAX_LEN: target sequence; pattern[pat_len-1] is the first bit expected, pattern[0] the last.
REQ-010 pat_len  input  LEN_W: number of active pattern bits.
REQ-011 overlap  input  1: 1 = overlapping detection, 0 = non-overlapping.
REQ-012 out  output  1: registered single-cycle match pulse.
REQ-013 match_cnt  output  CNT_W: saturating count of matches since the last reset or cfg_load.
REQ-014 active  output  1: detector is configured and accepting bits.
REQ-015 cfg_err  output  1: last cfg_load carried an illegal pat_len.

Function
REQ-016 Two-state control FSM, IDLE and ACTIVE; IDLE after reset.
REQ-017 IDLE: in_valid ignored, out=0, active=0.
REQ-018 cfg_load with 2 <= pat_len <= MAX_LEN: latch config, clear history, fill counter and match_cnt, set cfg_err=0, go to ACTIVE.
REQ-019 cfg_load with pat_len <2 or >MAX_LEN: clear match_cnt, set cfg_err=1, go to IDLE.
REQ-020 cfg_load is legal in either state; config changes take effect only through cfg_load.
REQ-021 ACTIVE, accepted bit: history shifts left, new bit enters hist[0]; fill counter increments, saturating at MAX_LEN.
REQ-022 Match condition, evaluated on the updated history:
  - fill >= latched pat_len;
  - hist[k] == pattern[k] for all k < pat_len.
  Bits above pat_len are ignored.
REQ-023 On a match, out=1 for exactly the one cycle following the accepting edge; latency one clock.
REQ-024 On a match, match_cnt increments by 1 and holds at all-ones (2^CNT_W-1) when saturated.
REQ-025 overlap=1: fill counter is not cleared on a match, so a match suffix may begin the next match.
REQ-026 overlap=0: fill counter is cleared to 0 on a match; no bit of a matched sequence contributes to a later match.
REQ-027 Edge with in_valid=0: history, fill and match_cnt hold; out=0 on the following cycle.
REQ-028 cfg_load and in_valid on the same edge: cfg_load wins, the data bit is discarded, out=0.
REQ-029 Only bits accepted since the last cfg_load can form a match; no match before pat_len bits have been accepted.

Reset
REQ-030 rst=1 asynchronously forces:
  - FSM=IDLE;
  - history, fill and latched config = 0;
  - out=0, match_cnt=0, active=0, cfg_err=0.
REQ-031 Reset asserted mid-sequence discards partial matches; a cfg_load is required after release.

Verification
REQ-032 pattern=3'b101, pat_len=3, overlap=1; bits 1,0,1,0,1 on consecutive cycles -> out pulses after the 3rd and 5th bits; match_cnt=2.
REQ-033 Same stream with overlap=0 -> one pulse, after the 3rd bit; match_cnt=1. Stream 1,0,1,1,0,1 -> pulses after bits 3 and 6; match_cnt=2.
REQ-034 pattern=3'b101, overlap=1; bits 1,0,1 with in_valid=0 gaps of 2 cycles between bits -> single pulse one cycle after the 3rd accepted bit; no pulse during the gaps.
REQ-035 CNT_W=2, pattern=2'b11, pat_len=2, overlap=1; six 1s -> pulses after bits 2 through 6; match_cnt reaches 3 and holds at 3.
REQ-036 cfg_load with pat_len=0, then pat_len=MAX_LEN+1 -> cfg_err=1, active=0, no pulses. Follow with a legal cfg_load -> cfg_err=0, active=1.
REQ-037 Bits 1,0 accepted, then rst pulse, then cfg_load (pattern=3'b101), then bit 1 -> no pulse; a pulse requires a fresh 1,0,1 after the cfg_load.
